board_reset_seq: RTL

Parametrised multi-channel reset-release sequencer for the host board. It takes over from the fixed single-counter MAC reset delay and drives N downstream reset domains, such as MAC, PCIe glue and DDR controllers. Channels are released in index order with a programmable gap between them. On selected channels, the sequencer waits for a ready/calibration indication before continuing. Lost readiness and timeouts trigger bounded retries, and a sticky fault is raised when the retries run out.

---
 rtl/board_reset_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/board_reset_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/board_reset_pkg.sv
// Shared definitions for the board reset-release sequencer.
//   state_e   : sequencer states
//   cnt_width : width of the shared cycle counter, large enough to hold the
//               longest of the hold, gap and ready-timeout intervals
package board_reset_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_RETRY,
    ST_FAULT
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned stage_delay,
                                            input int unsigned timeout);
    int unsigned m;
    m = hold_cycles;
    if (stage_delay > m) m = stage_delay;
    if (timeout > m) m = timeout;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous level input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous input
//   q_o    : synchronised output, two clk_i edges after d_i changes
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/board_reset_seq.sv
// Multi-channel reset-release sequencer.
// Holds all channels in reset, releases them in index order with a gap,
// optionally waits for each channel's ready, and retries the whole sequence
// on timeout or ready loss until the retry budget is exhausted.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   restart   : synchronous pulse, aborts and reruns from HOLD
//   ch_ready  : per-channel ready (asynchronous, synchronised here)
//   ch_rst_n  : per-channel active-low reset outputs (registered)
//   done      : all channels released and all waited channels ready
//   fault     : retries exhausted (sticky until restart / rst_n)
//   fault_ch  : channel that caused the last timeout or ready loss
//   retry_cnt : retries consumed in the current run
module board_reset_seq
  import board_reset_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       HOLD_CYCLES = 10,
  parameter int unsigned       STAGE_DELAY = 1000,
  parameter logic [NUM_CH-1:0] WAIT_MASK   = '1,
  parameter int unsigned       TIMEOUT     = 65535,
  parameter int unsigned       MAX_RETRIES = 3,
  localparam int unsigned      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned      RC_W        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              done,
  output logic              fault,
  output logic [CH_W-1:0]   fault_ch,
  output logic [RC_W-1:0]   retry_cnt
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_DELAY, TIMEOUT);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  LAST_IDX  = CH_W'(NUM_CH - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRIES);

  logic [NUM_CH-1:0] rdy;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [CH_W-1:0]   fault_ch_q, fault_ch_d;
  logic [RC_W-1:0]   retry_q, retry_d;

  logic              lost;
  logic [CH_W-1:0]   lost_ch;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    sync_2ff u_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (ch_ready[g]),
      .q_o    (rdy[g])
    );
  end

  // Lowest-index waited channel whose ready has dropped.
  always_comb begin
    lost    = 1'b0;
    lost_ch = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (WAIT_MASK[i] && !rdy[i] && !lost) begin
        lost    = 1'b1;
        lost_ch = CH_W'(i);
      end
    end
  end

  // Channel resets are registered: the bit for a channel is set on the same
  // edge that enters RELEASE for it, so it reads 1 while RELEASE is active.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ch_rst_n_d = ch_rst_n_q;
    retry_d    = retry_q;
    fault_ch_d = fault_ch_q;

    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d       = ST_RELEASE;
          cnt_d         = '0;
          idx_d         = '0;
          ch_rst_n_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        cnt_d = '0;
        if (WAIT_MASK[idx_q])       state_d = ST_WAIT;
        else if (idx_q == LAST_IDX) state_d = ST_DONE;
        else                        state_d = ST_GAP;
      end

      ST_WAIT: begin
        if (rdy[idx_q]) begin
          cnt_d   = '0;
          state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_GAP;
        end else if (cnt_q == TO_LAST) begin
          cnt_d      = '0;
          state_d    = ST_RETRY;
          fault_ch_d = idx_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d             = '0;
          state_d           = ST_RELEASE;
          idx_d             = idx_q + CH_W'(1);
          ch_rst_n_d[idx_d] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (lost) begin
          cnt_d      = '0;
          state_d    = ST_RETRY;
          fault_ch_d = lost_ch;
        end
      end

      ST_RETRY: begin
        cnt_d      = '0;
        ch_rst_n_d = '0;
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RC_W'(1);
          state_d = ST_HOLD;
        end else begin
          state_d = ST_FAULT;
        end
      end

      ST_FAULT: begin
        cnt_d      = '0;
        ch_rst_n_d = '0;
      end

      default: begin
        state_d    = ST_HOLD;
        cnt_d      = '0;
        ch_rst_n_d = '0;
      end
    endcase

    // restart overrides every decision above, including a coincident
    // timeout or ready loss.
    if (restart) begin
      state_d    = ST_HOLD;
      cnt_d      = '0;
      idx_d      = '0;
      ch_rst_n_d = '0;
      retry_d    = '0;
      fault_ch_d = '0;
    end

    done_d  = (state_d == ST_DONE);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      ch_rst_n_q <= '0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      fault_ch_q <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ch_rst_n_q <= ch_rst_n_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      fault_ch_q <= fault_ch_d;
      retry_q    <= retry_d;
    end
  end

  assign ch_rst_n  = ch_rst_n_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign fault_ch  = fault_ch_q;
  assign retry_cnt = retry_q;

endmodule
